// File: rtl/pe_array_ctrl_pkg.sv
// rtl/pe_array_ctrl_pkg.sv - shared state encoding and sizing for the PE array sequencer
package pe_array_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    SWAP   = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  localparam int NUM1_DEF = 16;
  localparam int NUM2_DEF = 16;
  localparam int DW_DEF   = 32;
  localparam int MW_DEF   = 8;

  // Input skew plus array traversal plus output deskew, accept to result.
  function automatic int res_lat(input int n1, input int n2);
    return n1 + n2;
  endfunction

  localparam int RES_LAT = res_lat(NUM1_DEF, NUM2_DEF);

endpackage

// File: rtl/pe_array_ctrl_skew_line.sv
// rtl/pe_array_ctrl_skew_line.sv - triangular per-lane delay line (skew or deskew)
module skew_line
  import pe_array_ctrl_pkg::*;
#(
  parameter int N       = NUM1_DEF,
  parameter int DW      = DW_DEF,
  parameter bit REVERSE = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N*DW-1:0] din,
  output logic [N*DW-1:0] dout
);

  for (genvar i = 0; i < N; i++) begin : g_lane
    localparam int D = REVERSE ? (N - 1 - i) : i;
    if (D == 0) begin : g_pass
      assign dout[i*DW +: DW] = din[i*DW +: DW];
    end else begin : g_dly
      logic [DW-1:0] sr [D];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int k = 0; k < D; k++) sr[k] <= '0;
        end else begin
          sr[0] <= din[i*DW +: DW];
          for (int k = 1; k < D; k++) sr[k] <= sr[k-1];
        end
      end
      assign dout[i*DW +: DW] = sr[D-1];
    end
  end

endmodule

// File: rtl/pe_array_ctrl.sv
// rtl/pe_array_ctrl.sv - tile sequencer for the weight-stationary systolic PE array
module pe_array_ctrl
  import pe_array_ctrl_pkg::*;
#(
  parameter int NUM1 = NUM1_DEF,
  parameter int NUM2 = NUM2_DEF,
  parameter int DW   = DW_DEF,
  parameter int MW   = MW_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic [MW-1:0]     m_rows,
  output logic              busy,
  output logic              done,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [NUM2*DW-1:0] b_data,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [NUM1*DW-1:0] a_data,
  output logic              arr_EN,
  output logic              arr_SELECTOR,
  output logic              arr_B_EN,
  output logic [NUM1*DW-1:0] arr_A_left,
  output logic [NUM2*DW-1:0] arr_B_above,
  input  logic [NUM2*DW-1:0] arr_sum,
  output logic              res_valid,
  output logic [NUM2*DW-1:0] res_data
);

  localparam int LAT = res_lat(NUM1, NUM2);
  localparam int BW  = $clog2(NUM1) + 1;

  state_t             state;
  logic [MW-1:0]      m_lat;
  logic [MW-1:0]      m_cnt;
  logic [BW-1:0]      b_cnt;
  logic [LAT-1:0]     tag_sr;
  logic [NUM1*DW-1:0] a_stage;
  logic [NUM2*DW-1:0] desk;
  logic               a_fire;
  logic               b_fire;

  assign b_fire      = b_valid & b_ready;
  assign a_fire      = a_valid & a_ready;
  assign arr_B_EN    = b_fire;
  assign arr_B_above = b_ready ? b_data : '0;
  assign res_valid   = tag_sr[LAT-1];

  // Control outputs are registered from the next-state decision.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      m_lat        <= '0;
      m_cnt        <= '0;
      b_cnt        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      b_ready      <= 1'b0;
      a_ready      <= 1'b0;
      arr_EN       <= 1'b0;
      arr_SELECTOR <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          m_lat   <= m_rows;
          m_cnt   <= '0;
          b_cnt   <= '0;
          state   <= LOAD_W;
          busy    <= 1'b1;
          arr_EN  <= 1'b1;
          b_ready <= 1'b1;
        end
        LOAD_W: if (b_fire) begin
          b_cnt <= b_cnt + 1'b1;
          if (b_cnt == BW'(NUM1 - 1)) begin
            state        <= SWAP;
            b_ready      <= 1'b0;
            arr_SELECTOR <= ~arr_SELECTOR;
          end
        end
        SWAP: begin
          if (m_lat == '0) begin
            state <= DRAIN;
          end else begin
            state   <= STREAM;
            a_ready <= 1'b1;
          end
        end
        STREAM: if (a_fire) begin
          m_cnt <= m_cnt + 1'b1;
          if (m_cnt == m_lat - 1'b1) begin
            state   <= DRAIN;
            a_ready <= 1'b0;
          end
        end
        DRAIN: if (tag_sr[LAT-2:0] == '0) begin
          // The last tag is leaving this cycle, so done lines up right behind it.
          state  <= IDLE;
          done   <= 1'b1;
          busy   <= 1'b0;
          arr_EN <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      a_stage  <= '0;
      tag_sr   <= '0;
      res_data <= '0;
    end else begin
      a_stage <= a_fire ? a_data : '0;
      tag_sr  <= {tag_sr[LAT-2:0], a_fire};
      if (tag_sr[LAT-2]) res_data <= desk;
    end
  end

  skew_line #(.N(NUM1), .DW(DW), .REVERSE(1'b0)) u_skew (
    .clk   (CLK),
    .reset (RESET),
    .din   (a_stage),
    .dout  (arr_A_left)
  );

  skew_line #(.N(NUM2), .DW(DW), .REVERSE(1'b1)) u_deskew (
    .clk   (CLK),
    .reset (RESET),
    .din   (arr_sum),
    .dout  (desk)
  );

endmodule

// File: tb/tb_pe_array_ctrl.sv
// tb/tb_pe_array_ctrl.sv - scoreboard bench for pe_array_ctrl with a behavioural systolic array
module tb_pe_array_ctrl;
  import pe_array_ctrl_pkg::*;

  localparam int NUM1 = 16;
  localparam int NUM2 = 16;
  localparam int DW   = 32;
  localparam int MW   = 8;
  localparam int LAT  = RES_LAT;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              start;
  logic [MW-1:0]     m_rows;
  logic              busy, done;
  logic              b_valid, b_ready;
  logic [NUM2*DW-1:0] b_data;
  logic              a_valid, a_ready;
  logic [NUM1*DW-1:0] a_data;
  logic              arr_EN, arr_SELECTOR, arr_B_EN;
  logic [NUM1*DW-1:0] arr_A_left;
  logic [NUM2*DW-1:0] arr_B_above;
  logic [NUM2*DW-1:0] arr_sum;
  logic              res_valid;
  logic [NUM2*DW-1:0] res_data;

  pe_array_ctrl #(.NUM1(NUM1), .NUM2(NUM2), .DW(DW), .MW(MW)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .m_rows(m_rows), .busy(busy), .done(done),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .arr_EN(arr_EN), .arr_SELECTOR(arr_SELECTOR), .arr_B_EN(arr_B_EN),
    .arr_A_left(arr_A_left), .arr_B_above(arr_B_above), .arr_sum(arr_sum),
    .res_valid(res_valid), .res_data(res_data)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int res_cnt = 0;
  int last_res_cyc = 0;
  bit sel_exp = 1'b0;

  typedef struct { int cyc; logic [NUM2*DW-1:0] data; } exp_t;
  exp_t sbq[$];

  logic [DW-1:0] wm   [NUM1][NUM2];
  logic [DW-1:0] wsh  [NUM1][NUM2];
  logic [DW-1:0] wact [NUM1][NUM2];
  logic [DW-1:0] hreg [NUM1][NUM2];
  logic [DW-1:0] preg [NUM1][NUM2];
  logic [DW-1:0] ain  [NUM1][NUM2];
  logic [DW-1:0] pnx  [NUM1][NUM2];
  logic          sel_q = 1'b0;

  // Array model: activations move right, partial sums move down, bottom row is combinational.
  always_comb begin
    arr_sum = '0;
    for (int i = 0; i < NUM1; i++) begin
      for (int j = 0; j < NUM2; j++) begin
        if (j == 0) ain[i][j] = arr_A_left[i*DW +: DW];
        else        ain[i][j] = hreg[i][j-1];
        if (i == 0) pnx[i][j] = ain[i][j] * wact[i][j];
        else        pnx[i][j] = preg[i-1][j] + ain[i][j] * wact[i][j];
      end
    end
    for (int j = 0; j < NUM2; j++) arr_sum[j*DW +: DW] = pnx[NUM1-1][j];
  end

  always @(posedge CLK) begin
    for (int i = 0; i < NUM1; i++) begin
      for (int j = 0; j < NUM2; j++) begin
        hreg[i][j] <= ain[i][j];
        preg[i][j] <= pnx[i][j];
        if (arr_B_EN) wsh[i][j] <= (i == 0) ? arr_B_above[j*DW +: DW] : wsh[i-1][j];
        if (arr_SELECTOR != sel_q) wact[i][j] <= wsh[i][j];
      end
    end
    sel_q <= arr_SELECTOR;
  end

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [NUM2*DW-1:0] act, input logic [NUM2*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] aval(input int v, input int i);
    return DW'((i + 1) * (v + 1));
  endfunction

  function automatic logic [NUM2*DW-1:0] exp_res(input int v);
    logic [NUM2*DW-1:0] r;
    logic [DW-1:0] acc;
    r = '0;
    for (int j = 0; j < NUM2; j++) begin
      acc = '0;
      for (int i = 0; i < NUM1; i++) acc = acc + aval(v, i) * wm[i][j];
      r[j*DW +: DW] = acc;
    end
    return r;
  endfunction

  task automatic set_weights(input bit identity);
    for (int i = 0; i < NUM1; i++)
      for (int j = 0; j < NUM2; j++)
        wm[i][j] = identity ? DW'(i == j) : DW'(i + 2 * j + 1);
  endtask

  // Scoreboard monitor: every presented result must match the oldest expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (res_valid) begin
      res_cnt++;
      last_res_cyc = cyc;
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL res_unexpected: res_valid at cycle %0d, expected none", cyc);
      end else begin
        e = sbq.pop_front();
        chk_int("res_cycle", cyc, e.cyc);
        chk_vec("res_data", res_data, e.data);
      end
    end
  end

  task automatic check_idle_zero(input string tag);
    chk_int({tag, "_busy"}, busy, 0);
    chk_int({tag, "_done"}, done, 0);
    chk_int({tag, "_b_ready"}, b_ready, 0);
    chk_int({tag, "_a_ready"}, a_ready, 0);
    chk_int({tag, "_arr_EN"}, arr_EN, 0);
    chk_int({tag, "_arr_SELECTOR"}, arr_SELECTOR, 0);
    chk_int({tag, "_arr_B_EN"}, arr_B_EN, 0);
    chk_int({tag, "_res_valid"}, res_valid, 0);
    chk_vec({tag, "_arr_A_left"}, arr_A_left, '0);
    chk_vec({tag, "_arr_B_above"}, arr_B_above, '0);
    chk_vec({tag, "_res_data"}, res_data, '0);
  endtask

  task automatic run_tile(input int m, input bit b_tog, input bit a_gap, input bit poke, input bit do_reset);
    int beat, tick, guard, ldcyc, benb, bbad, v, res0, dcnt;
    res0 = res_cnt;
    @(negedge CLK);
    start = 1'b1; m_rows = MW'(m);
    @(negedge CLK);
    start = 1'b0;
    chk_int("busy_after_start", busy, 1);
    chk_int("arr_EN_after_start", arr_EN, 1);
    beat = 0; tick = 0; ldcyc = 0; benb = 0; bbad = 0; guard = 0;
    while (beat < NUM1 && guard < 200) begin
      b_valid = b_tog ? ((tick % 2) == 0) : 1'b1;
      for (int j = 0; j < NUM2; j++) b_data[j*DW +: DW] = wm[NUM1-1-beat][j];
      #1;
      if (b_ready) ldcyc++;
      if (arr_B_EN) benb++;
      if (arr_B_EN !== (b_valid & b_ready) || (b_ready && arr_B_above !== b_data)) bbad++;
      if (b_valid && b_ready) beat++;
      tick++; guard++;
      @(negedge CLK);
    end
    b_valid = 1'b0;
    chk_int("b_ready_cycles", ldcyc, b_tog ? 31 : 16);
    chk_int("b_en_beats", benb, NUM1);
    chk_int("b_en_mirror_errors", bbad, 0);
    chk_int("swap_b_ready", b_ready, 0);
    sel_exp = ~sel_exp;
    chk_int("swap_selector", arr_SELECTOR, sel_exp);
    @(negedge CLK);
    chk_int("stream_a_ready", a_ready, (m > 0) ? 1 : 0);
    v = 0; tick = 0; guard = 0;
    while (v < m && guard < 400) begin
      if (do_reset && v == 3) begin
        RESET = 1'b1; a_valid = 1'b1;
        @(negedge CLK);
        RESET = 1'b0; a_valid = 1'b0;
        check_idle_zero("after_reset");
        sbq.delete();
        sel_exp = 1'b0;
        dcnt = 0;
        repeat (60) begin
          @(negedge CLK);
          if (done) dcnt++;
        end
        chk_int("no_done_after_reset", dcnt, 0);
        chk_int("no_res_after_reset", res_cnt - res0, 0);
        return;
      end
      a_valid = a_gap ? ((tick % 3) != 1) : 1'b1;
      for (int i = 0; i < NUM1; i++) a_data[i*DW +: DW] = aval(v, i);
      start  = poke && (tick == 2);
      m_rows = (poke && tick == 2) ? MW'(99) : MW'(m);
      if (a_valid && a_ready) begin
        sbq.push_back('{cyc + LAT, exp_res(v)});
        v++;
      end
      tick++; guard++;
      @(negedge CLK);
    end
    a_valid = 1'b0; start = 1'b0;
    chk_int("stream_beats", v, m);
    chk_int("a_ready_after_last", a_ready, 0);
    guard = 0;
    while (done !== 1'b1 && guard < 300) begin
      @(negedge CLK);
      guard++;
    end
    chk_int("done_seen", done, 1);
    chk_int("busy_at_done", busy, 0);
    chk_int("res_count", res_cnt - res0, m);
    if (m > 0) chk_int("done_after_last_res", cyc, last_res_cyc + 1);
    chk_int("scoreboard_empty", sbq.size(), 0);
    @(negedge CLK);
    chk_int("done_one_cycle", done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1; start = 1'b0; m_rows = '0;
    b_valid = 1'b0; b_data = '0; a_valid = 1'b0; a_data = '0;
    for (int i = 0; i < NUM1; i++)
      for (int j = 0; j < NUM2; j++) begin
        wsh[i][j] = '0; wact[i][j] = '0; hreg[i][j] = '0; preg[i][j] = '0;
      end
    repeat (3) @(negedge CLK);
    check_idle_zero("reset");
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    set_weights(1'b1); run_tile(4, 1'b0, 1'b0, 1'b0, 1'b0);
    set_weights(1'b0); run_tile(3, 1'b1, 1'b0, 1'b0, 1'b0);
    set_weights(1'b1); run_tile(6, 1'b0, 1'b1, 1'b0, 1'b0);
    run_tile(0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_weights(1'b0); run_tile(8, 1'b0, 1'b0, 1'b0, 1'b1);
    set_weights(1'b0); run_tile(5, 1'b0, 1'b1, 1'b1, 1'b0);

    repeat (5) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_array_ctrl.md
Name: pe_array_ctrl

Overview:
Sequencer for the weight-stationary NUM1 x NUM2 systolic PE array. For each tile it:
- accepts NUM1 weight beats and flows them down the array;
- flips the weight-select so the loaded weights become active;
- streams M activation vectors into the array with input skew;
- deskews the bottom-row partial sums and presents one aligned result vector per accepted activation vector.

It sits between the tile DMA/buffers and the PE array instance.

Parameters:
NUM1, 16, number of PE rows (length of an activation vector)
NUM2, 16, number of PE columns (length of a weight/result vector)
DW, 32, element width in bits
MW, 8, width of the per-tile activation-vector count

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
start  in  1  begin a tile; sampled only in IDLE
m_rows  in  MW  number of activation vectors in the tile; latched on start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the tile's last result
b_valid  in  1  weight beat valid
b_ready  out  1  weight beat ready
b_data  in  NUM2*DW  weight beat (one array row)
a_valid  in  1  activation beat valid
a_ready  out  1  activation beat ready
a_data  in  NUM1*DW  activation vector; element i feeds row i
arr_EN  out  1  array enable
arr_SELECTOR  out  1  array weight-bank select
arr_B_EN  out  1  array weight-flow enable
arr_A_left  out  NUM1*DW  skewed activations to the array
arr_B_above  out  NUM2*DW  weights to the array top row
arr_sum  in  NUM2*DW  array bottom-row partial sums
res_valid  out  1  result vector valid (no backpressure)
res_data  out  NUM2*DW  deskewed result vector

Behaviour:
- Reset values: all outputs 0, arr_SELECTOR 0, state IDLE, all skew/deskew/tag registers cleared. Reset mid-tile abandons the tile; no done pulse.
- Reset polarity and synchronicity are fixed: RESET is sampled on the rising edge of CLK, active high.
- States: IDLE, LOAD_W, SWAP, STREAM, DRAIN.
- IDLE:
  - start=1 latches m_rows and moves to LOAD_W.
  - start in any other state is ignored.
- LOAD_W:
  - b_ready=1.
  - arr_B_EN = b_valid & b_ready; arr_B_above = b_data.
  - A beat counter counts accepted beats. Beat k (0-based) ends in row NUM1-1-k.
  - b_valid low holds arr_B_EN low; weights do not move.
  - After the NUM1-th accepted beat, move to SWAP.
- SWAP:
  - One cycle; arr_SELECTOR toggles.
  - Next state: STREAM, or DRAIN if the latched m_rows == 0.
- STREAM:
  - a_ready=1.
  - Each accepted beat enters the skew line with tag=1.
  - A cycle with a_valid=0 inserts a zero bubble with tag=0. The pipeline never stalls.
  - After m_rows beats are accepted, move to DRAIN.
- DRAIN:
  - Feed zero bubbles until the tag pipeline is empty.
  - Then pulse done for one cycle and return to IDLE.
- arr_EN = 1 in LOAD_W, SWAP, STREAM and DRAIN; 0 in IDLE.
- Skew: row i of arr_A_left is delayed i cycles (row 0 undelayed, registered).
- Deskew: column j of arr_sum is delayed NUM2-1-j cycles.
- Latency: res_valid for an activation beat accepted at cycle t asserts at t+NUM1+NUM2, in acceptance order. This is realised with a 1-bit tag shift register of that depth.
- res_data holds its previous value when res_valid=0.
- Arithmetic: data passes through unmodified; no width changes.
- Counters: the m_rows counter is MW bits; the weight-beat counter is clog2(NUM1)+1 bits. No wrap-around is possible within a tile.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=0, LOAD_W=1, SWAP=2, STREAM=3, DRAIN=4);
  - default NUM1/NUM2/DW;
  - the latency constant RES_LAT = NUM1+NUM2.
- One sub-module, skew_line: parameterised triangular delay of N lanes × DW with per-lane depth (lane index, or N-1-index when reversed). It is instantiated twice: input skew and output deskew.

Test Plan:
- Reset then start with m_rows=4 and b_valid/a_valid always 1:
  - b_ready high for exactly 16 cycles;
  - arr_SELECTOR goes 0→1 at SWAP;
  - 4 res_valid pulses, first at accept+32;
  - done one cycle after the 4th result.
- b_valid toggled 1010… during LOAD_W: arr_B_EN mirrors accepted beats only; SWAP occurs after the 16th accepted beat (32 cycles).
- Identity weights, a_data row i = i+1, with a_valid gaps in STREAM: res_data equals the expected matmul column values; res_valid gaps match the input gaps.
- m_rows=0: LOAD_W → SWAP → DRAIN; zero res_valid pulses; done asserted.
- RESET asserted for one cycle mid-STREAM: next cycle all outputs are 0 and arr_SELECTOR is 0; no done; a new start runs normally.
- start pulsed while busy: ignored; m_rows unchanged; the tile completes with the original count.
